cpu_agu: RTL
============

Name: cpu_agu

Overview:
- Parametrised 6502-family address-generation unit. It sequences the operand-fetch bus cycles for every cc=01 addressing mode and produces the effective address (EA).
- Sits between the controller FSM and the memory bus. The controller pulses `start` at decode with `pc` pointing at the first operand byte, then consumes `ea`/`op_len` on `done`.
- Generalises the fixed IMM/ABS path to all eight modes, a configurable data width and direct-page base, and page-cross penalty cycles.

Parameters:
- DATA_W, 8, data/index width; ADDR_W = 2*DATA_W is derived and is not overridable.
- ZP_BASE, 0, ADDR_W-bit base of zero/direct page; zero-page EA = ZP_BASE | {0, byte}.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin sequence; accepted only when busy=0
- mode  in  3  bbb encoding: 0 INX (zp,X), 1 ZP, 2 IMM, 3 ABS, 4 INY (zp),Y, 5 ZPX, 6 ABSY, 7 ABSX
- force_fixup  in  1  store/RMW: always take the fixup cycle in ABSX/ABSY/INY
- pc  in  ADDR_W  address of first operand byte
- x, y  in  DATA_W  index registers
- d_in  in  DATA_W  read data; valid for `addr` in the same cycle, sampled at the closing edge
- addr  out  ADDR_W  bus address
- rd_en  out  1  bus read strobe
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse: ea/page_cross/op_len valid
- ea  out  ADDR_W  effective address
- page_cross  out  1  indexed add carried out of the low byte
- op_len  out  2  operand bytes consumed (1 or 2)

Behaviour:
- Reset: state IDLE; addr, ea = 0; rd_en, busy, done, page_cross = 0; op_len = 0. rst during any state aborts the sequence next edge with no `done`.
- Latching: pc, x, y, mode and force_fixup are latched on the accepting edge. Later input changes have no effect. `start` while busy is ignored.
- Latency L: edges from the accepting edge to the first cycle with done=1.
  - IMM 1
  - ZP 2
  - ZPX 3
  - ABS 3
  - ABSX/ABSY 3, or 4 on cross or force_fixup
  - INX 5
  - INY 4, or 5 on cross or force_fixup
- busy is high for the L-1 cycles between. In the done cycle busy=0 and a new `start` may be accepted.
- States: IDLE, OP0 (read pc), OP1 (read pc+1), IDX (internal add), PTRL, PTRH, FIX.
  - IMM: IDLE->done. ea = pc. op_len = 1. No bus read.
  - ZP: OP0. ea = ZP_BASE | b.
  - ZPX: OP0, IDX. ea = ZP_BASE | ((b+x) mod 2^DATA_W). Never carries into the page.
  - ABS: OP0, OP1. ea = {hi, lo}. op_len = 2.
  - ABSX/ABSY: OP0, OP1, then FIX if carry(lo+idx) or force_fixup. ea = {hi,lo} + idx, full ADDR_W add, wraps at 2^ADDR_W.
  - INX: OP0, IDX, PTRL at ZP_BASE|p, PTRH at ZP_BASE|((p+1) mod 2^DATA_W), where p = (b+x) mod 2^DATA_W. ea = {hi, lo}.
  - INY: OP0, PTRL at ZP_BASE|b, PTRH at ZP_BASE|((b+1) mod 2^DATA_W), then FIX as for ABSY. ea = {hi,lo} + y.
- rd_en = 1 and addr driven in OP0, OP1, PTRL and PTRH.
- In IDX/FIX without the feature: rd_en = 0 and addr holds its previous value.
- page_cross is set only for ABSX/ABSY/INY carries. It is 0 when only force_fixup caused FIX.
- ea, page_cross and op_len hold their values until the next done.

Optional Feature:
- Macro: CPU_AGU_DUMMY_READ_EN.
- With the macro defined, IDX and FIX issue NES-accurate dummy reads (rd_en = 1):
  - ZPX/INX IDX reads ZP_BASE|b.
  - ABSX/ABSY/INY FIX reads {hi, (lo+idx) mod 2^DATA_W}.
- Without the macro these cycles are bus-idle (rd_en = 0). Cycle counts are identical in both builds.

Test Plan:
- ABSX, pc=0x8000, mem[8000]=0xF0, mem[8001]=0x12, x=0x20 -> done at L=4, ea=0x1310, page_cross=1, op_len=2. With the macro: dummy read of 0x1210.
- ABSX, same memory, x=0x05, force_fixup=0 -> L=3, ea=0x12F5, page_cross=0. With force_fixup=1 -> L=4, page_cross=0.
- ZPX, mem[pc]=0xFF, x=0x02 -> L=3, ea=0x0001 (zero-page wrap).
- INX, mem[pc]=0xFE, x=0x01, mem[00FF]=0x34, mem[0000]=0x12 -> reads at 0x00FF then 0x0000, L=5, ea=0x1234.
- INY, mem[pc]=0x40, mem[0040]=0xFF, mem[0041]=0x20, y=0x01 -> L=5, ea=0x2100, page_cross=1.
- Abort/back-to-back: assert rst in PTRL of INX -> no done, all outputs 0 next cycle. Then IMM start in a done cycle -> accepted, done 1 edge later with ea=pc.

Source files
------------

// File: rtl/cpu_agu_if.sv
// Bus bundle between the controller/memory side and the cpu_agu address-generation unit.
interface cpu_agu_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned ADDR_W = 2 * DATA_W;

  logic              start;
  logic [2:0]        mode;
  logic              force_fixup;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic [DATA_W-1:0] d_in;
  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ea;
  logic              page_cross;
  logic [1:0]        op_len;

  modport master (
    output start, mode, force_fixup, pc, x, y, d_in,
    input  addr, rd_en, busy, done, ea, page_cross, op_len
  );

  modport slave (
    input  start, mode, force_fixup, pc, x, y, d_in,
    output addr, rd_en, busy, done, ea, page_cross, op_len
  );
endinterface

// File: rtl/cpu_agu.sv
// 6502-family address-generation unit: sequences operand fetches for all cc=01
// addressing modes and returns the effective address.
// Optional macro CPU_AGU_DUMMY_READ_EN: IDX/FIX cycles issue dummy bus reads
// instead of idling the bus; cycle counts are unchanged.
module cpu_agu #(
  parameter int unsigned          DATA_W  = 8,
  parameter logic [2*DATA_W-1:0]  ZP_BASE = '0
) (
  input logic      clk,
  input logic      rst,
  cpu_agu_if.slave bus
);
  localparam int unsigned ADDR_W = 2 * DATA_W;

`ifdef CPU_AGU_DUMMY_READ_EN
  localparam bit DUMMY_RD = 1'b1;
`else
  localparam bit DUMMY_RD = 1'b0;
`endif

  localparam logic [2:0] M_INX  = 3'd0;
  localparam logic [2:0] M_ZP   = 3'd1;
  localparam logic [2:0] M_IMM  = 3'd2;
  localparam logic [2:0] M_ABS  = 3'd3;
  localparam logic [2:0] M_INY  = 3'd4;
  localparam logic [2:0] M_ZPX  = 3'd5;
  localparam logic [2:0] M_ABSY = 3'd6;
  localparam logic [2:0] M_ABSX = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_OP0, S_OP1, S_IDX, S_PTRL, S_PTRH, S_FIX} state_t;

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              rd_en_q, rd_en_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic [ADDR_W-1:0] ea_q, ea_nxt;
  logic              pcx_q, pcx_nxt;
  logic [1:0]        op_len_q, op_len_nxt;

  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [DATA_W-1:0] x_q, x_nxt;
  logic [DATA_W-1:0] y_q, y_nxt;
  logic [2:0]        mode_q, mode_nxt;
  logic              ff_q, ff_nxt;
  logic [DATA_W-1:0] lo_q, lo_nxt;
  logic [DATA_W-1:0] hi_q, hi_nxt;
  logic [DATA_W-1:0] ptr_q, ptr_nxt;

  logic [DATA_W-1:0] idx_c;
  logic [DATA_W:0]   lo_sum_c;
  logic              carry_c;
  logic [DATA_W-1:0] hi_src_c;
  logic [ADDR_W-1:0] idx_ea_c;
  logic [1:0]        len_c;

  logic              fin;
  logic [ADDR_W-1:0] fin_ea;
  logic              fin_pcx;
  logic              idx_step;

  // Zero/direct-page address of an operand byte
  function automatic logic [ADDR_W-1:0] zp(input logic [DATA_W-1:0] b);
    return ZP_BASE | ADDR_W'(b);
  endfunction

  // Indexed-add datapath shared by ABSX/ABSY/INY
  assign idx_c    = (mode_q == M_ABSX) ? x_q : y_q;
  assign lo_sum_c = {1'b0, lo_q} + {1'b0, idx_c};
  assign carry_c  = lo_sum_c[DATA_W];
  assign hi_src_c = (state_q == S_FIX) ? hi_q : bus.d_in;
  assign idx_ea_c = {hi_src_c, lo_q} + ADDR_W'(idx_c);
  assign len_c    = (mode_q == M_ABS || mode_q == M_ABSX || mode_q == M_ABSY) ? 2'd2 : 2'd1;

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state_q;
    addr_nxt   = addr_q;
    rd_en_nxt  = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    ea_nxt     = ea_q;
    pcx_nxt    = pcx_q;
    op_len_nxt = op_len_q;
    pc_nxt     = pc_q;
    x_nxt      = x_q;
    y_nxt      = y_q;
    mode_nxt   = mode_q;
    ff_nxt     = ff_q;
    lo_nxt     = lo_q;
    hi_nxt     = hi_q;
    ptr_nxt    = ptr_q;
    fin        = 1'b0;
    fin_ea     = ea_q;
    fin_pcx    = 1'b0;
    idx_step   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pc_nxt   = bus.pc;
          x_nxt    = bus.x;
          y_nxt    = bus.y;
          mode_nxt = bus.mode;
          ff_nxt   = bus.force_fixup;
          if (bus.mode == M_IMM) begin
            done_nxt   = 1'b1;
            ea_nxt     = bus.pc;
            pcx_nxt    = 1'b0;
            op_len_nxt = 2'd1;
          end else begin
            state_nxt = S_OP0;
            busy_nxt  = 1'b1;
            rd_en_nxt = 1'b1;
            addr_nxt  = bus.pc;
          end
        end
      end
      S_OP0: begin
        busy_nxt = 1'b1;
        lo_nxt   = bus.d_in;
        ptr_nxt  = bus.d_in;
        case (mode_q)
          M_ZP: begin
            fin    = 1'b1;
            fin_ea = zp(bus.d_in);
          end
          M_ZPX, M_INX: begin
            state_nxt = S_IDX;
            if (DUMMY_RD) begin
              rd_en_nxt = 1'b1;
              addr_nxt  = zp(bus.d_in);
            end
          end
          M_INY: begin
            state_nxt = S_PTRL;
            rd_en_nxt = 1'b1;
            addr_nxt  = zp(bus.d_in);
          end
          default: begin
            state_nxt = S_OP1;
            rd_en_nxt = 1'b1;
            addr_nxt  = pc_q + ADDR_W'(1);
          end
        endcase
      end
      S_OP1: begin
        busy_nxt = 1'b1;
        hi_nxt   = bus.d_in;
        if (mode_q == M_ABS) begin
          fin    = 1'b1;
          fin_ea = {bus.d_in, lo_q};
        end else begin
          idx_step = 1'b1;
        end
      end
      S_IDX: begin
        busy_nxt = 1'b1;
        if (mode_q == M_ZPX) begin
          fin    = 1'b1;
          fin_ea = zp(DATA_W'(ptr_q + x_q));
        end else begin
          ptr_nxt   = DATA_W'(ptr_q + x_q);
          state_nxt = S_PTRL;
          rd_en_nxt = 1'b1;
          addr_nxt  = zp(DATA_W'(ptr_q + x_q));
        end
      end
      S_PTRL: begin
        busy_nxt  = 1'b1;
        lo_nxt    = bus.d_in;
        state_nxt = S_PTRH;
        rd_en_nxt = 1'b1;
        addr_nxt  = zp(DATA_W'(ptr_q + DATA_W'(1)));
      end
      S_PTRH: begin
        busy_nxt = 1'b1;
        hi_nxt   = bus.d_in;
        if (mode_q == M_INX) begin
          fin    = 1'b1;
          fin_ea = {bus.d_in, lo_q};
        end else begin
          idx_step = 1'b1;
        end
      end
      S_FIX: begin
        fin     = 1'b1;
        fin_ea  = idx_ea_c;
        fin_pcx = carry_c;
      end
      default: state_nxt = S_IDLE;
    endcase

    // High byte just arrived: take the fixup cycle or finish now
    if (idx_step) begin
      if (carry_c || ff_q) begin
        state_nxt = S_FIX;
        if (DUMMY_RD) begin
          rd_en_nxt = 1'b1;
          addr_nxt  = {bus.d_in, lo_sum_c[DATA_W-1:0]};
        end
      end else begin
        fin    = 1'b1;
        fin_ea = idx_ea_c;
      end
    end

    // Completion: publish results for one done cycle
    if (fin) begin
      state_nxt  = S_IDLE;
      busy_nxt   = 1'b0;
      rd_en_nxt  = 1'b0;
      done_nxt   = 1'b1;
      ea_nxt     = fin_ea;
      pcx_nxt    = fin_pcx;
      op_len_nxt = len_c;
    end
  end

  // State, output and latched-operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ea_q     <= '0;
      pcx_q    <= 1'b0;
      op_len_q <= 2'd0;
      pc_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= 3'd0;
      ff_q     <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_nxt;
      addr_q   <= addr_nxt;
      rd_en_q  <= rd_en_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      ea_q     <= ea_nxt;
      pcx_q    <= pcx_nxt;
      op_len_q <= op_len_nxt;
      pc_q     <= pc_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      mode_q   <= mode_nxt;
      ff_q     <= ff_nxt;
      lo_q     <= lo_nxt;
      hi_q     <= hi_nxt;
      ptr_q    <= ptr_nxt;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ea         = ea_q;
  assign bus.page_cross = pcx_q;
  assign bus.op_len     = op_len_q;
endmodule
